// File: rtl/ql_irq_pkg.sv
// Shared constants for the QL interrupt controller: register map and source limit.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ql_irq_pkg;

  // Register select values on bus_addr
  localparam logic [1:0] IRQ_A_PEND = 2'd0;  // read pending, write 1 to acknowledge
  localparam logic [1:0] IRQ_A_MASK = 2'd1;  // source enable mask
  localparam logic [1:0] IRQ_A_MODE = 2'd2;  // 0 = edge, 1 = level
  localparam logic [1:0] IRQ_A_OVR  = 2'd3;  // read overrun, write 1 to clear

  // Widest register / bus word; also the upper bound on NSRC
  localparam int IRQ_MAX_SRC = 16;

endpackage

// File: rtl/ql_irq_ctrl_if.sv
// Register bus between the CPU-side decoder and the interrupt controller.
// Latency: writes take effect on the next clk edge; reads are combinational.
// Backpressure: none, the slave never stalls (zero wait states).
//   bus_wr    one-cycle write strobe
//   bus_addr  register select (see ql_irq_pkg)
//   bus_wdata write data
//   bus_rdata read data for the selected register
interface ql_irq_ctrl_if;
  logic        bus_wr;
  logic [1:0]  bus_addr;
  logic [15:0] bus_wdata;
  logic [15:0] bus_rdata;

  modport master (output bus_wr, output bus_addr, output bus_wdata, input  bus_rdata);
  modport slave  (input  bus_wr, input  bus_addr, input  bus_wdata, output bus_rdata);
endinterface

// File: rtl/ql_irq_chan.sv
// One interrupt source: gated edge/level capture with ack and overrun tracking.
// Latency: source edge or ack at cycle N is visible on pending at N+1.
// Backpressure: none; a second edge while pending flags overrun instead of stalling.
//   src/mask/mode  raw level, enable and edge(0)/level(1) select
//   ack/ovr_clr    write-1-to-clear strobes for pending and overrun
//   pending/overrun registered status
module ql_irq_chan (
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic mask,
  input  logic mode,
  input  logic ack,
  input  logic ovr_clr,
  output logic pending,
  output logic overrun
);

  logic g;
  logic g_d;
  logic rise;

  // Mask gates before the edge detector, so unmasking a high source is an edge.
  assign g    = src & mask;
  assign rise = g & ~g_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      g_d     <= 1'b0;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      // g_d tracks g in both modes so a level->edge switch sees no stale edge
      g_d <= g;

      // Edge mode: a new edge beats a same-cycle ack
      if (mode)
        pending <= g;
      else if (rise)
        pending <= 1'b1;
      else if (ack)
        pending <= 1'b0;

      // An edge that lands on an un-acked pending bit is lost; flag it.
      // Setting beats a same-cycle clear.
      if (!mode && rise && pending && !ack)
        overrun <= 1'b1;
      else if (ovr_clr)
        overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/ql_irq_ctrl.sv
// NSRC-source interrupt controller: mask/mode registers, per-source capture,
// priority vector and merge into the 68008 IPL pair.
// Latency: src edge at N -> pending/irq/ipl at N+1; ack at N -> cleared at N+1.
// Backpressure: none; register bus is zero-wait, reads are combinational.
//   src      raw source levels (already in clk domain)
//   ext_ipl  active-low IPL pair from the IPC
//   bus      register read/write port
//   ipl      active-low IPL to the CPU; irq = any pending; irq_vec = winning index
module ql_irq_ctrl
  import ql_irq_pkg::*;
#(
  parameter int NSRC           = 8,
  parameter int PRIO_LOW_FIRST = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NSRC-1:0]   src,
  input  logic [1:0]        ext_ipl,
  ql_irq_ctrl_if.slave      bus,
  output logic [1:0]        ipl,
  output logic              irq,
  output logic [3:0]        irq_vec
);

  logic [NSRC-1:0] mask_q;
  logic [NSRC-1:0] mode_q;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] ovr;
  logic [NSRC-1:0] wdata_n;
  logic            wr_pend;
  logic            wr_mask;
  logic            wr_mode;
  logic            wr_ovr;
  logic            wdata_unused;

  // Only the low NSRC bits of a write are meaningful.
  assign wdata_n      = bus.bus_wdata[NSRC-1:0];
  assign wdata_unused = ^bus.bus_wdata;

  assign wr_pend = bus.bus_wr && (bus.bus_addr == IRQ_A_PEND);
  assign wr_mask = bus.bus_wr && (bus.bus_addr == IRQ_A_MASK);
  assign wr_mode = bus.bus_wr && (bus.bus_addr == IRQ_A_MODE);
  assign wr_ovr  = bus.bus_wr && (bus.bus_addr == IRQ_A_OVR);

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= '0;
      mode_q <= '0;
    end else begin
      if (wr_mask) mask_q <= wdata_n;
      if (wr_mode) mode_q <= wdata_n;
    end
  end

  for (genvar i = 0; i < NSRC; i++) begin : g_chan
    ql_irq_chan u_chan (
      .clk     (clk),
      .reset   (reset),
      .src     (src[i]),
      .mask    (mask_q[i]),
      .mode    (mode_q[i]),
      .ack     (wr_pend & wdata_n[i]),
      .ovr_clr (wr_ovr & wdata_n[i]),
      .pending (pend[i]),
      .overrun (ovr[i])
    );
  end

  // Read mux; unused upper bits read as zero.
  always_comb begin
    bus.bus_rdata = '0;
    case (bus.bus_addr)
      IRQ_A_PEND: bus.bus_rdata[NSRC-1:0] = pend;
      IRQ_A_MASK: bus.bus_rdata[NSRC-1:0] = mask_q;
      IRQ_A_MODE: bus.bus_rdata[NSRC-1:0] = mode_q;
      default:    bus.bus_rdata[NSRC-1:0] = ovr;
    endcase
  end

  // Priority encode: scan from the lowest-priority end so the last hit wins.
  always_comb begin
    irq_vec = '0;
    if (PRIO_LOW_FIRST != 0) begin
      for (int i = NSRC - 1; i >= 0; i--)
        if (pend[i]) irq_vec = 4'(i);
    end else begin
      for (int i = 0; i < NSRC; i++)
        if (pend[i]) irq_vec = 4'(i);
    end
  end

  assign irq = |pend;
  // Our request pulls IPL1 low (level 2); the IPC pair passes through otherwise.
  assign ipl = {ext_ipl[1] & ~irq, ext_ipl[0]};

endmodule

// File: tb/tb_ql_irq_ctrl.sv
// Scoreboard bench: two controllers (NSRC=8 low-first, NSRC=5 high-first) share stimulus;
// a behavioural model pushes expected outputs per cycle, a monitor pops and compares.
// Directed scenarios first, then randomized traffic with occasional resets.
module tb_ql_irq_ctrl;

  logic       clk;
  logic       reset;
  logic [7:0] src;
  logic [1:0] ext_ipl;
  logic [1:0] ipl_a, ipl_b;
  logic       irq_a, irq_b;
  logic [3:0] vec_a, vec_b;

  ql_irq_ctrl_if bus_a();
  ql_irq_ctrl_if bus_b();

  ql_irq_ctrl #(.NSRC(8), .PRIO_LOW_FIRST(1)) dut_a (
    .clk(clk), .reset(reset), .src(src), .ext_ipl(ext_ipl),
    .bus(bus_a.slave), .ipl(ipl_a), .irq(irq_a), .irq_vec(vec_a)
  );

  ql_irq_ctrl #(.NSRC(5), .PRIO_LOW_FIRST(0)) dut_b (
    .clk(clk), .reset(reset), .src(src[4:0]), .ext_ipl(ext_ipl),
    .bus(bus_b.slave), .ipl(ipl_b), .irq(irq_b), .irq_vec(vec_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] rd_a, rd_b;
    logic        irq_a, irq_b;
    logic [3:0]  vec_a, vec_b;
    logic [1:0]  ipl_a, ipl_b;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_mis = 0;
  int   cyc   = 0;

  // Model state, one bit per source (8 sources; the 5-source DUT sees bits 4:0)
  bit [7:0] m_pend, m_mask, m_mode, m_ovr, m_gprev;

  // Current bus inputs (shared by both DUTs)
  logic        b_wr;
  logic [1:0]  b_addr;
  logic [15:0] b_wdata;

  function automatic logic [15:0] reg_view(input logic [1:0] a, input bit [7:0] keep);
    bit [7:0] v;
    case (a)
      2'd0:    v = m_pend;
      2'd1:    v = m_mask;
      2'd2:    v = m_mode;
      default: v = m_ovr;
    endcase
    return {8'h00, v & keep};
  endfunction

  // Expected outputs for the current state and the inputs just applied
  function automatic exp_t expect_now();
    exp_t e;
    bit [4:0] p5;
    p5 = m_pend[4:0];
    e.rd_a  = reg_view(b_addr, 8'hFF);
    e.rd_b  = reg_view(b_addr, 8'h1F);
    e.irq_a = (m_pend != 0);
    e.irq_b = (p5 != 0);
    e.vec_a = 4'd0;
    for (int i = 0; i < 8; i++)
      if (m_pend[i]) begin e.vec_a = 4'(i); break; end
    e.vec_b = 4'd0;
    for (int i = 4; i >= 0; i--)
      if (p5[i]) begin e.vec_b = 4'(i); break; end
    e.ipl_a = {ext_ipl[1] & ~e.irq_a, ext_ipl[0]};
    e.ipl_b = {ext_ipl[1] & ~e.irq_b, ext_ipl[0]};
    return e;
  endfunction

  // Advance the model by one clock using the rules of the controller
  task automatic model_clock();
    bit [7:0] np, no;
    bit g, rise, ack, clr;
    if (reset) begin
      m_pend = 0; m_mask = 0; m_mode = 0; m_ovr = 0; m_gprev = 0;
      return;
    end
    for (int i = 0; i < 8; i++) begin
      g    = src[i] && m_mask[i];
      rise = g && !m_gprev[i];
      ack  = b_wr && b_addr == 2'd0 && b_wdata[i];
      clr  = b_wr && b_addr == 2'd3 && b_wdata[i];
      if (m_mode[i])      np[i] = g;
      else if (rise)      np[i] = 1'b1;
      else if (ack)       np[i] = 1'b0;
      else                np[i] = m_pend[i];
      if (!m_mode[i] && rise && m_pend[i] && !ack) no[i] = 1'b1;
      else if (clr)                               no[i] = 1'b0;
      else                                        no[i] = m_ovr[i];
      m_gprev[i] = g;
    end
    m_pend = np;
    m_ovr  = no;
    if (b_wr && b_addr == 2'd1) m_mask = b_wdata[7:0];
    if (b_wr && b_addr == 2'd2) m_mode = b_wdata[7:0];
  endtask

  // Apply one cycle of stimulus: push expectation, advance model, clock.
  task automatic drive(input logic rst, input logic [7:0] s, input logic wr,
                       input logic [1:0] a, input logic [15:0] d, input logic [1:0] e);
    reset   = rst;
    src     = s;
    ext_ipl = e;
    b_wr = wr; b_addr = a; b_wdata = d;
    bus_a.bus_wr = wr; bus_a.bus_addr = a; bus_a.bus_wdata = d;
    bus_b.bus_wr = wr; bus_b.bus_addr = a; bus_b.bus_wdata = d;
    exp_q.push_back(expect_now());
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
    n_vec++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, got, want);
    end
  endtask

  // Monitor: every output sample is compared against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cyc++;
        chk("rdata_a", bus_a.bus_rdata, e.rd_a);
        chk("rdata_b", bus_b.bus_rdata, e.rd_b);
        chk("irq_a",   16'(irq_a),      16'(e.irq_a));
        chk("irq_b",   16'(irq_b),      16'(e.irq_b));
        chk("vec_a",   16'(vec_a),      16'(e.vec_a));
        chk("vec_b",   16'(vec_b),      16'(e.vec_b));
        chk("ipl_a",   16'(ipl_a),      16'(e.ipl_a));
        chk("ipl_b",   16'(ipl_b),      16'(e.ipl_b));
      end
    end
  end

  initial begin
    logic [7:0] rs;
    m_pend = 0; m_mask = 0; m_mode = 0; m_ovr = 0; m_gprev = 0;
    reset = 1'b1; src = '0; ext_ipl = 2'b11;
    b_wr = 1'b0; b_addr = '0; b_wdata = '0;
    bus_a.bus_wr = 1'b0; bus_a.bus_addr = '0; bus_a.bus_wdata = '0;
    bus_b.bus_wr = 1'b0; bus_b.bus_addr = '0; bus_b.bus_wdata = '0;
    // Registers are unknown until the first reset edge; no checks yet
    repeat (2) @(posedge clk);
    #1;

    // Reset state, every register readable
    for (int a = 0; a < 4; a++) drive(1, 8'h00, 0, 2'(a), 16'h0, 2'b11);

    // src[0] edge, then ack
    drive(0, 8'h00, 1, 2'd1, 16'h0001, 2'b11);
    drive(0, 8'h01, 0, 2'd0, 16'h0,    2'b11);
    drive(0, 8'h01, 0, 2'd0, 16'h0,    2'b11);
    drive(0, 8'h01, 1, 2'd0, 16'h0001, 2'b11);
    drive(0, 8'h00, 0, 2'd0, 16'h0,    2'b11);

    // src[3] held high, mask toggled to retrigger
    drive(0, 8'h08, 1, 2'd1, 16'h0008, 2'b11);
    drive(0, 8'h08, 0, 2'd0, 16'h0,    2'b11);
    drive(0, 8'h08, 1, 2'd0, 16'h0008, 2'b11);
    drive(0, 8'h08, 1, 2'd1, 16'h0000, 2'b11);
    drive(0, 8'h08, 1, 2'd1, 16'h0008, 2'b11);
    drive(0, 8'h08, 0, 2'd0, 16'h0,    2'b11);
    drive(0, 8'h08, 1, 2'd0, 16'h0008, 2'b11);

    // Level mode on src[2]: pending follows a 3-cycle pulse, ack ignored
    drive(0, 8'h00, 1, 2'd2, 16'h0004, 2'b11);
    drive(0, 8'h00, 1, 2'd1, 16'h0004, 2'b11);
    drive(0, 8'h04, 0, 2'd0, 16'h0,    2'b11);
    drive(0, 8'h04, 1, 2'd0, 16'h0004, 2'b11);
    drive(0, 8'h04, 0, 2'd0, 16'h0,    2'b11);
    drive(0, 8'h00, 0, 2'd3, 16'h0,    2'b11);
    drive(0, 8'h00, 0, 2'd0, 16'h0,    2'b11);

    // Overrun on src[1], ack colliding with an edge, overrun clear
    drive(0, 8'h00, 1, 2'd2, 16'h0000, 2'b11);
    drive(0, 8'h00, 1, 2'd1, 16'h0002, 2'b11);
    drive(0, 8'h02, 0, 2'd0, 16'h0,    2'b11);
    drive(0, 8'h00, 0, 2'd0, 16'h0,    2'b11);
    drive(0, 8'h02, 0, 2'd3, 16'h0,    2'b11);
    drive(0, 8'h00, 0, 2'd3, 16'h0,    2'b11);
    drive(0, 8'h02, 1, 2'd0, 16'h0002, 2'b11);
    drive(0, 8'h00, 0, 2'd0, 16'h0,    2'b11);
    drive(0, 8'h00, 1, 2'd3, 16'h0002, 2'b11);
    drive(0, 8'h00, 0, 2'd3, 16'h0,    2'b11);
    drive(0, 8'h00, 1, 2'd0, 16'h0002, 2'b11);

    // pending = 0x28: priority both ways, IPC merge
    drive(0, 8'h00, 1, 2'd1, 16'h0028, 2'b10);
    drive(0, 8'h28, 0, 2'd0, 16'h0,    2'b10);
    drive(0, 8'h28, 0, 2'd0, 16'h0,    2'b01);
    drive(0, 8'h28, 0, 2'd0, 16'h0,    2'b00);

    // Mask width clipping, then reset racing a write
    drive(0, 8'h00, 1, 2'd1, 16'hFFFF, 2'b11);
    drive(0, 8'h00, 0, 2'd1, 16'h0,    2'b11);
    drive(1, 8'hFF, 1, 2'd2, 16'hFFFF, 2'b11);
    for (int a = 0; a < 4; a++) drive(0, 8'h00, 0, 2'(a), 16'h0, 2'b11);

    // Randomized traffic
    rs = '0;
    for (int n = 0; n < 3000; n++) begin
      rs = rs ^ (8'($urandom) & 8'($urandom));
      drive(($urandom_range(0, 99) == 0), rs, ($urandom_range(0, 3) == 0),
            2'($urandom), 16'($urandom), 2'($urandom));
    end

    // Drain the scoreboard with a bounded wait
    for (int t = 0; t < 5 && exp_q.size() > 0; t++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_vec++;
      n_mis++;
      $display("FAIL drain: got %0d outstanding expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/ql_irq_ctrl.md
# ql_irq_ctrl

Parametrised interrupt controller for the QL core. It generalises the fixed five-source ZX8302 interrupt logic to NSRC sources. Each source can be set to edge or level mode, and the controller adds write-1-to-clear acknowledge, per-source overrun flags and a priority vector. It sits between the peripheral event sources (gap, vsync, xint, microdrive, RTC, expansion) and the 68008 IPL lines, and merges its request with the IPC-driven IPL pair.

## Interface
- NSRC, 8: number of interrupt sources, 1..16.
- PRIO_LOW_FIRST, 1: when 1, the lowest index has highest priority; when 0, the highest index does.
- clk  in  1  system clock; every register updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- src  in  NSRC  raw source levels, already synchronous to clk.
- ext_ipl  in  2  active-low IPL pair from the IPC.
- bus_wr  in  1  one-cycle write strobe.
- bus_addr  in  2  register select: 0 pending/ack, 1 mask, 2 mode, 3 overrun.
- bus_wdata  in  16  write data; bits above NSRC-1 are ignored.
- bus_rdata  out  16  register contents selected by bus_addr; bits above NSRC-1 read 0.
- ipl  out  2  active-low IPL to the CPU.
- irq  out  1  OR of all pending bits.
- irq_vec  out  4  index of the highest-priority pending source; 0 when irq=0.

## Operation
- Gated source: g[i] = src[i] & mask[i]. The mask is applied before edge detection, so unmasking a source that is already high raises an edge. This preserves the QL "toggling the mask triggers irqs" behaviour.
- Edge mode (mode[i]=0):
  - A rising edge is g[i] & ~g_d[i], where g_d is g delayed one cycle.
  - An edge sets pending[i].
  - Writing 1 to bit i at address 0 clears pending[i].
- Level mode (mode[i]=1):
  - pending[i] is loaded with g[i] every cycle.
  - Acknowledge writes have no effect.
  - overrun[i] is never set.
- Overrun: an edge on source i while pending[i] is already 1, with no clear in the same cycle, sets overrun[i]. Writing 1 to bit i at address 3 clears it.
- Simultaneous edge and ack on the same bit: the set wins. pending stays 1 and overrun is not set.
- Simultaneous overrun set and overrun clear: the set wins.
- A mask write or mode write replaces the whole field.
- Switching a source from edge to level takes effect the next cycle; pending then tracks g.
- Switching from level to edge leaves pending at its current value, and g_d continues to track g.
- irq = |pending.
- ipl = {ext_ipl[1] & ~irq, ext_ipl[0]}. Any pending source forces at least level 2.
- irq_vec is a combinational priority encode of pending, with direction set by PRIO_LOW_FIRST.
- Address 0 reads pending and address 3 reads overrun; neither read has side effects.

## Timing
- Reset values: pending=0, mask=0, mode=0, overrun=0, g_d=0, irq=0, irq_vec=0, ipl=ext_ipl.
- Because mask resets to 0, no spurious edge occurs on the first cycle after reset.
- Latency from a src rising edge (mask=1) at cycle N to pending, irq and ipl[1] low is cycle N+1.
- Latency from a bus_wr ack at cycle N to pending cleared is cycle N+1, so irq falls in the same cycle.
- bus_rdata is combinational from the registers and bus_addr, with zero wait states.
- Reset asserted mid-operation clears all state on the next edge and overrides any bus_wr in the same cycle.

## Structure
- Shared package ql_irq_pkg holds:
  - address constants IRQ_A_PEND=0, IRQ_A_MASK=1, IRQ_A_MODE=2, IRQ_A_OVR=3;
  - the maximum source count, 16.
- Sub-module ql_irq_chan, instantiated NSRC times, contains one source's g_d, pending and overrun logic. Its inputs are src, mask, mode, ack and ovr_clr; its outputs are pending and overrun.
- The top level contains the register file, the read mux, the priority encoder and the IPL merge.

## Test plan
- Reset then mask=0x01, src[0] rising: pending=0x01, irq=1 and ipl=2'b01 one cycle later. Write 0x01 to address 0: pending=0x00 and ipl=2'b11 on the next cycle.
- src[3] held high, then mask changes 0x00 to 0x08: pending[3] sets one cycle after the mask write. Mask back to 0x00 and then 0x08 again: pending[3] sets again.
- mode=0x04, mask=0x04, src[2] pulsed for 3 cycles: pending[2] is high for exactly 3 cycles, delayed by one. An ack write leaves it unchanged. overrun stays 0.
- Edge mode, src[1] toggled twice without ack: pending[1]=1 and overrun=0x02. Ack on the same cycle as a third edge: pending[1] stays 1. Write 0x02 to address 3: overrun=0.
- pending=0x28: irq_vec=3 with PRIO_LOW_FIRST=1 and irq_vec=5 with PRIO_LOW_FIRST=0. ext_ipl=2'b10 with irq=1 gives ipl=2'b00.
- NSRC=5: write 0xFFFF to the mask, then read address 1 returns 0x001F. Reset asserted together with a bus_wr: all registers read 0 afterwards.
